// File: rtl/pf_ddr4_dqsw_training_ctrl.sv
// pf_ddr4_dqsw_training_ctrl
//   Fabric-side DDR4 DQSW write-leveling controller for one byte lane.
//   Reloads the lane delay line to tap 0, then steps it one tap at a time.
//   At each tap it waits for the line to settle and majority-votes the DQ
//   feedback. The first low-to-high transition of the vote is the lock point.
//
// Ports
//   FAB_CLK, ARST_N             clock (rising edge), async active-low reset
//   TRAIN_START                 1-cycle start pulse (honoured in IDLE/DONE/ERR)
//   RX_DATA[1:0]                feedback; sample bit = RX_DATA[1] & RX_DATA[0]
//   DELAY_LINE_OUT_OF_RANGE     delay line exhausted -> abort with error
//   EYE_MONITOR_EARLY/LATE      eye monitor flags (optional feature)
//   DELAY_LINE_LOAD/MOVE        1-cycle delay-line control pulses
//   DELAY_LINE_DIRECTION        1 while busy (increment), 0 otherwise
//   EYE_MONITOR_CLEAR_FLAGS     1-cycle pulse on first settle cycle of each tap
//   TRAIN_BUSY/DONE/ERR         status; DONE and ERR are sticky
//   TAP_COUNT[TAP_W-1:0]        current tap, locked tap once DONE
//
// Configuration
//   DQSW_EYE_MONITOR_EN  when defined, EARLY/LATE veto sample votes and the
//                        eye monitor flags are cleared at the start of each tap.

module pf_ddr4_dqsw_training_ctrl #(
  parameter int NUM_TAPS      = 128,
  parameter int TAP_W         = 7,
  parameter int SETTLE_CYCLES = 8,
  parameter int SAMPLE_COUNT  = 4
) (
  input  logic             FAB_CLK,
  input  logic             ARST_N,
  input  logic             TRAIN_START,
  input  logic [1:0]       RX_DATA,
  input  logic             DELAY_LINE_OUT_OF_RANGE,
  input  logic             EYE_MONITOR_EARLY,
  input  logic             EYE_MONITOR_LATE,
  output logic             DELAY_LINE_LOAD,
  output logic             DELAY_LINE_MOVE,
  output logic             DELAY_LINE_DIRECTION,
  output logic             EYE_MONITOR_CLEAR_FLAGS,
  output logic             TRAIN_BUSY,
  output logic             TRAIN_DONE,
  output logic             TRAIN_ERR,
  output logic [TAP_W-1:0] TAP_COUNT
);

  typedef enum logic [2:0] {
    IDLE, LOAD, SETTLE, SAMPLE, MOVE, DONE, ERR
  } state_t;

  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int SMP_W = $clog2(SAMPLE_COUNT + 1);

  localparam logic [TAP_W-1:0] LAST_TAP   = TAP_W'(NUM_TAPS - 1);
  localparam logic [SET_W-1:0] SET_LAST   = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [SMP_W-1:0] SMP_END    = SMP_W'(SAMPLE_COUNT);
  localparam logic [SMP_W-1:0] HI_THRESH  = SMP_W'(SAMPLE_COUNT / 2 + 1);

  state_t           state;
  logic [SET_W-1:0] settle_cnt;
  logic [SMP_W-1:0] smp_cnt;
  logic [SMP_W-1:0] ones;
  logic             seen_low;
  logic             sample_bit;
  logic             hi;
  logic             range_abort;

`ifdef DQSW_EYE_MONITOR_EN
  assign sample_bit = RX_DATA[1] & RX_DATA[0] & ~(EYE_MONITOR_EARLY | EYE_MONITOR_LATE);
`else
  logic unused_eye;
  assign sample_bit              = RX_DATA[1] & RX_DATA[0];
  assign unused_eye              = EYE_MONITOR_EARLY | EYE_MONITOR_LATE;
  assign EYE_MONITOR_CLEAR_FLAGS = 1'b0;
`endif

  assign hi          = (ones >= HI_THRESH);
  assign range_abort = DELAY_LINE_OUT_OF_RANGE &&
                       (state == SETTLE || state == SAMPLE || state == MOVE);

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state                   <= IDLE;
      settle_cnt              <= '0;
      smp_cnt                 <= '0;
      ones                    <= '0;
      seen_low                <= 1'b0;
      TAP_COUNT               <= '0;
      DELAY_LINE_LOAD         <= 1'b0;
      DELAY_LINE_MOVE         <= 1'b0;
      DELAY_LINE_DIRECTION    <= 1'b0;
      TRAIN_BUSY              <= 1'b0;
      TRAIN_DONE              <= 1'b0;
      TRAIN_ERR               <= 1'b0;
`ifdef DQSW_EYE_MONITOR_EN
      EYE_MONITOR_CLEAR_FLAGS <= 1'b0;
`endif
    end else begin
      DELAY_LINE_LOAD <= 1'b0;
      DELAY_LINE_MOVE <= 1'b0;
`ifdef DQSW_EYE_MONITOR_EN
      EYE_MONITOR_CLEAR_FLAGS <= 1'b0;
`endif
      if (range_abort) begin
        // The MOVE pulse already went out, so the line did step.
        if (state == MOVE) TAP_COUNT <= TAP_COUNT + 1'b1;
        state                <= ERR;
        TRAIN_ERR            <= 1'b1;
        TRAIN_BUSY           <= 1'b0;
        DELAY_LINE_DIRECTION <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE, ERR: begin
            if (TRAIN_START) begin
              state                <= LOAD;
              DELAY_LINE_LOAD      <= 1'b1;
              DELAY_LINE_DIRECTION <= 1'b1;
              TRAIN_BUSY           <= 1'b1;
              TRAIN_DONE           <= 1'b0;
              TRAIN_ERR            <= 1'b0;
              TAP_COUNT            <= '0;
              seen_low             <= 1'b0;
            end
          end
          LOAD: begin
            state      <= SETTLE;
            settle_cnt <= '0;
`ifdef DQSW_EYE_MONITOR_EN
            EYE_MONITOR_CLEAR_FLAGS <= 1'b1;
`endif
          end
          SETTLE: begin
            if (settle_cnt == SET_LAST) begin
              state   <= SAMPLE;
              smp_cnt <= '0;
              ones    <= '0;
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end
          SAMPLE: begin
            if (smp_cnt != SMP_END) begin
              smp_cnt <= smp_cnt + 1'b1;
              ones    <= ones + SMP_W'(sample_bit);
            end else begin
              // Decision cycle: lock needs a low tap seen before this high one.
              if (!hi) seen_low <= 1'b1;
              if (hi && seen_low) begin
                state                <= DONE;
                TRAIN_DONE           <= 1'b1;
                TRAIN_BUSY           <= 1'b0;
                DELAY_LINE_DIRECTION <= 1'b0;
              end else if (TAP_COUNT == LAST_TAP) begin
                state                <= ERR;
                TRAIN_ERR            <= 1'b1;
                TRAIN_BUSY           <= 1'b0;
                DELAY_LINE_DIRECTION <= 1'b0;
              end else begin
                state           <= MOVE;
                DELAY_LINE_MOVE <= 1'b1;
              end
            end
          end
          MOVE: begin
            TAP_COUNT  <= TAP_COUNT + 1'b1;
            state      <= SETTLE;
            settle_cnt <= '0;
`ifdef DQSW_EYE_MONITOR_EN
            EYE_MONITOR_CLEAR_FLAGS <= 1'b1;
`endif
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pf_ddr4_dqsw_training_ctrl.sv
module tb_pf_ddr4_dqsw_training_ctrl;

  logic       FAB_CLK = 1'b0;
  logic       ARST_N  = 1'b1;
  logic       TRAIN_START = 1'b0;
  logic [1:0] RX_DATA = 2'b00;
  logic       OOR   = 1'b0;
  logic       EARLY = 1'b0;
  logic       LATE  = 1'b0;
  logic       LOAD, MOVE, DIR, CLEAR, BUSY, DONE, ERR;
  logic [6:0] TAP;

  pf_ddr4_dqsw_training_ctrl #(
    .NUM_TAPS(128), .TAP_W(7), .SETTLE_CYCLES(8), .SAMPLE_COUNT(4)
  ) dut (
    .FAB_CLK                 (FAB_CLK),
    .ARST_N                  (ARST_N),
    .TRAIN_START             (TRAIN_START),
    .RX_DATA                 (RX_DATA),
    .DELAY_LINE_OUT_OF_RANGE (OOR),
    .EYE_MONITOR_EARLY       (EARLY),
    .EYE_MONITOR_LATE        (LATE),
    .DELAY_LINE_LOAD         (LOAD),
    .DELAY_LINE_MOVE         (MOVE),
    .DELAY_LINE_DIRECTION    (DIR),
    .EYE_MONITOR_CLEAR_FLAGS (CLEAR),
    .TRAIN_BUSY              (BUSY),
    .TRAIN_DONE              (DONE),
    .TRAIN_ERR               (ERR),
    .TAP_COUNT               (TAP)
  );

  always #5 FAB_CLK = ~FAB_CLK;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", tag, actual, expected);
    end
  endtask

  typedef struct {
    int done;
    int err;
    int tap;
    int moves;
  } exp_t;
  exp_t sb[$];

  // Delay-line / feedback model state, owned by the monitor process.
  int         votes [128];
  logic [1:0] lo_val = 2'b00;
  int btap = 0, phase = 0, cyc = 0, last_pulse = -1;
  int n_moves = 0, n_loads = 0, n_clears = 0;
  int viol_interval = 0, viol_excl = 0, viol_dir = 0;
  int oor_at = -1, ign_at = -1;
  bit oor_wait = 0, start_req = 0, start_check = 0;

  // Monitor + input driver, everything on the falling edge.
  // Phase 0 is the LOAD/MOVE cycle; phases 9..12 are the sampled cycles.
  initial begin
    forever begin
      @(negedge FAB_CLK);
      cyc++;
      if (start_check) begin
        check_eq("load_after_start", LOAD, 1);
        start_check = 0;
      end
      if (oor_wait) begin
        check_eq("oor_err_next_cycle", ERR, 1);
        check_eq("oor_busy_drop", BUSY, 0);
        oor_wait = 0;
      end
      if (LOAD && MOVE) viol_excl++;
      if (DIR !== BUSY) viol_dir++;
      if (CLEAR) n_clears++;
      if (LOAD) begin
        btap = 0; phase = 0; n_loads++; last_pulse = cyc;
      end else if (MOVE) begin
        if (last_pulse >= 0 && cyc - last_pulse != 14) viol_interval++;
        last_pulse = cyc; btap++; phase = 0; n_moves++;
      end else begin
        phase++;
      end
      RX_DATA = (phase >= 9 && phase < 9 + votes[btap & 127]) ? 2'b11 : lo_val;
      if (oor_at >= 0 && n_moves == oor_at && phase == 1) begin
        OOR = 1'b1; oor_wait = 1; oor_at = -1;
      end
      TRAIN_START = start_req;
      if (start_req) start_check = 1;
      start_req = 0;
      if (ign_at >= 0 && n_moves == ign_at && phase == 5) begin
        TRAIN_START = 1'b1; ign_at = -1;
      end
    end
  end

  task automatic set_votes(input int lo_first, input int lo_last, input int hi_first, input int pre_hi);
    // pre_hi: taps below lo_first are fully high when 1.
    for (int i = 0; i < 128; i++) begin
      if (i < lo_first)       votes[i] = pre_hi ? 4 : 0;
      else if (i <= lo_last)  votes[i] = 0;
      else if (i >= hi_first) votes[i] = 4;
      else                    votes[i] = 0;
    end
  endtask

  task automatic run_test(input string name, input int e_done, input int e_err, input int e_tap, input int e_moves);
    exp_t e;
    int   k;
    bit   seen_busy;
    n_moves = 0; n_loads = 0; n_clears = 0;
    viol_interval = 0; viol_excl = 0; viol_dir = 0;
    OOR = 1'b0;
    sb.push_back('{e_done, e_err, e_tap, e_moves});
    start_req = 1;
    seen_busy = 0;
    for (k = 0; k < 4000; k++) begin
      @(negedge FAB_CLK);
      if (seen_busy && !BUSY) break;
      if (BUSY) seen_busy = 1;
    end
    check_eq({name, "_finished"}, {31'd0, seen_busy && !BUSY}, 1);
    e = sb.pop_front();
    check_eq({name, "_done"},  DONE, e.done);
    check_eq({name, "_err"},   ERR,  e.err);
    check_eq({name, "_tap"},   TAP,  e.tap);
    check_eq({name, "_moves"}, n_moves, e.moves);
    check_eq({name, "_loads"}, n_loads, 1);
    check_eq({name, "_tap_period"}, viol_interval, 0);
    check_eq({name, "_load_move_excl"}, viol_excl, 0);
    check_eq({name, "_dir_vs_busy"}, viol_dir, 0);
`ifdef DQSW_EYE_MONITOR_EN
    check_eq({name, "_clears"}, n_clears, e.moves + 1);
`else
    check_eq({name, "_clears"}, n_clears, 0);
`endif
    repeat (5) @(negedge FAB_CLK);
    check_eq({name, "_sticky"}, {DONE, ERR, BUSY, TAP}, {e.done[0], e.err[0], 1'b0, e.tap[6:0]});
    OOR = 1'b0;
  endtask

  initial begin
    int k;
    for (int i = 0; i < 128; i++) votes[i] = 0;
    #2 ARST_N = 1'b0;
    #1 check_eq("reset_outputs", {LOAD, MOVE, DIR, CLEAR, BUSY, DONE, ERR, TAP}, 0);
    repeat (3) @(negedge FAB_CLK);
    ARST_N = 1'b1;
    repeat (2) @(negedge FAB_CLK);
    check_eq("idle_after_reset", {LOAD, MOVE, BUSY, DONE, ERR, TAP}, 0);

    // Lock at tap 37; a stray start pulse mid-search must be ignored.
    set_votes(0, 36, 37, 0);
    ign_at = 3;
    run_test("t1_lock37", 1, 0, 37, 37);

    // Starting inside the high region: first high is not a lock.
    set_votes(10, 19, 20, 1);
    run_test("t2_lock20", 1, 0, 20, 20);

    // Never high; low value 01 must not count as a 1 vote.
    set_votes(0, 127, 200, 0);
    lo_val = 2'b01;
    run_test("t3_noloc", 0, 1, 127, 127);
    lo_val = 2'b00;

    // Out of range after the 5th MOVE.
    set_votes(0, 127, 200, 0);
    oor_at = 5;
    run_test("t4_oor", 0, 1, 5, 5);

    // Majority vote boundaries: 1/4 and 2/4 are low, 3/4 is high.
    set_votes(0, 127, 200, 0);
    votes[12] = 1; votes[13] = 2; votes[15] = 3;
    run_test("t5_vote", 1, 0, 15, 15);

    // Reset during SETTLE at tap 50, then a clean restart.
    set_votes(0, 127, 200, 0);
    n_moves = 0;
    start_req = 1;
    for (k = 0; k < 2000; k++) begin
      @(negedge FAB_CLK);
      if (n_moves == 50 && phase == 3) break;
    end
    check_eq("t6_reached_tap50", n_moves, 50);
    #2 ARST_N = 1'b0;
    #1 check_eq("t6_async_reset", {LOAD, MOVE, DIR, CLEAR, BUSY, DONE, ERR, TAP}, 0);
    repeat (2) @(negedge FAB_CLK);
    ARST_N = 1'b1;
    repeat (2) @(negedge FAB_CLK);
    check_eq("t6_idle", {BUSY, DONE, ERR, TAP}, 0);
    set_votes(0, 36, 37, 0);
    run_test("t6_restart", 1, 0, 37, 37);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0d expected=0", 1);
    $fatal(1, "timeout");
  end

endmodule
